weighted_rr_arbiter: RTL and testbench

Parametrised N-port round-robin arbiter. It keeps the existing hold-until-release grant semantics and adds per-port weighted quanta. A port keeps its grant for at most weight[i] consecutive cycles while other ports are waiting, then the grant is pre-empted to the next requester in rotation. It sits in front of shared resources (bus master, memory port) and is selectable between zero-cycle (combinational) and registered grant timing.

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 36 +++
 rtl/weighted_rr_arbiter.sv | 115 +++++++++++
 tb/tb_weighted_rr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared helpers for round-robin arbiters: index-width sizing and one-hot decode.
package rr_arb_pkg;

    localparam int unsigned MAX_PORTS = 32;

    // Index width never collapses to zero, even for degenerate port counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned idx,
                                                    input int unsigned ports);
        logic [MAX_PORTS-1:0] result;
        result = '0;
        if (idx < ports) begin
            result = MAX_PORTS'(1) << idx;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating priority encoder: first set request at or after i_start, wrapping modulo PORTS.
module rr_priority_picker
    import rr_arb_pkg::*;
#(
    parameter int unsigned PORTS = 4,
    parameter int unsigned IDX_W = clog2_min1(PORTS)
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Explicit wrap keeps non-power-of-two port counts in range.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < int'(PORTS); k++) begin
            sum = {1'b0, i_start} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(PORTS)) begin
                sum = sum - (IDX_W+1)'(PORTS);
            end
            cand = sum[IDX_W-1:0];
            if (!o_found && i_req[cand]) begin
                o_found = 1'b1;
                o_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: hold-until-release ownership, pre-empted after
// weight[i] cycles when others wait; zero-cycle or registered grant timing.
module weighted_rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned WEIGHT_W   = 4,
    parameter int unsigned ZERO_CYCLE = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [PORTS-1:0]             i_req_vec,
    input  logic [PORTS*WEIGHT_W-1:0]    i_weight,
    output logic [PORTS-1:0]             o_grant_vec,
    output logic [clog2_min1(PORTS)-1:0] o_grant_idx,
    output logic                         o_grant_valid
);

    localparam int unsigned IDX_W = clog2_min1(PORTS);

    logic [IDX_W-1:0]    owner_idx_q, owner_idx_d;
    logic                owner_valid_q, owner_valid_d;
    logic [WEIGHT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [WEIGHT_W-1:0] owner_w;
    logic [WEIGHT_W-1:0] w_eff;
    logic [PORTS-1:0]    owner_mask;
    logic                others;
    logic                owner_req;
    logic                keep;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    logic                sel_valid;
    logic [IDX_W-1:0]    sel_idx;

    rr_priority_picker #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (i_req_vec),
        .i_start (ptr_q),
        .o_found (pick_found),
        .o_idx   (pick_idx)
    );

    // Owner's quantum, with zero treated as one.
    always_comb begin
        owner_w = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (owner_idx_q == IDX_W'(i)) begin
                owner_w = i_weight[i*int'(WEIGHT_W) +: WEIGHT_W];
            end
        end
        w_eff = (owner_w == '0) ? WEIGHT_W'(1) : owner_w;
    end

    always_comb begin
        owner_mask = owner_valid_q ? PORTS'(onehot(32'(owner_idx_q), PORTS)) : '0;
        others     = |(i_req_vec & ~owner_mask);
        owner_req  = |(i_req_vec & owner_mask);
        keep       = owner_valid_q && owner_req && !((hold_cnt_q >= w_eff) && others);
    end

    // Next-owner decision: keep, new grant (rotating scan), or idle.
    always_comb begin
        owner_idx_d   = owner_idx_q;
        owner_valid_d = owner_valid_q;
        hold_cnt_d    = hold_cnt_q;
        ptr_d         = ptr_q;
        if (keep) begin
            hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + WEIGHT_W'(1);
        end else if (pick_found) begin
            owner_idx_d   = pick_idx;
            owner_valid_d = 1'b1;
            hold_cnt_d    = WEIGHT_W'(1);
            ptr_d         = (pick_idx == IDX_W'(PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end else begin
            owner_idx_d   = '0;
            owner_valid_d = 1'b0;
            hold_cnt_d    = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_idx_q   <= '0;
            owner_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
            ptr_q         <= '0;
        end else begin
            owner_idx_q   <= owner_idx_d;
            owner_valid_q <= owner_valid_d;
            hold_cnt_q    <= hold_cnt_d;
            ptr_q         <= ptr_d;
        end
    end

    // Reset gates the outputs directly so the zero-cycle path is also forced low.
    always_comb begin
        if (ZERO_CYCLE != 0) begin
            sel_valid = owner_valid_d;
            sel_idx   = owner_idx_d;
        end else begin
            sel_valid = owner_valid_q;
            sel_idx   = owner_idx_q;
        end
        sel_valid     = sel_valid && !i_rst;
        o_grant_valid = sel_valid;
        o_grant_idx   = sel_valid ? sel_idx : '0;
        o_grant_vec   = sel_valid ? PORTS'(onehot(32'(sel_idx), PORTS)) : '0;
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter: one zero-cycle and one registered instance.
module tb_weighted_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_z, req_r;
    logic [15:0] w_z, w_r;
    logic [3:0]  gv_z, gv_r;
    logic [1:0]  gi_z, gi_r;
    logic        gval_z, gval_r;

    int n_chk;
    int n_fail;

    int seq2 [13] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0, 1, 1};

    weighted_rr_arbiter #(.PORTS(4), .WEIGHT_W(4), .ZERO_CYCLE(1)) dut_z (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_vec     (req_z),
        .i_weight      (w_z),
        .o_grant_vec   (gv_z),
        .o_grant_idx   (gi_z),
        .o_grant_valid (gval_z)
    );

    weighted_rr_arbiter #(.PORTS(4), .WEIGHT_W(4), .ZERO_CYCLE(0)) dut_r (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_vec     (req_r),
        .i_weight      (w_r),
        .o_grant_vec   (gv_r),
        .o_grant_idx   (gi_r),
        .o_grant_valid (gval_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk_z(input string tag, input logic [3:0] exp_vec);
        chk({tag, ".vec"},   32'(gv_z),   32'(exp_vec));
        chk({tag, ".idx"},   32'(gi_z),   32'(idx_of(exp_vec)));
        chk({tag, ".valid"}, 32'(gval_z), 32'(|exp_vec));
    endtask

    task automatic chk_r(input string tag, input logic [3:0] exp_vec);
        chk({tag, ".vec"},   32'(gv_r),   32'(exp_vec));
        chk({tag, ".idx"},   32'(gi_r),   32'(idx_of(exp_vec)));
        chk({tag, ".valid"}, 32'(gval_r), 32'(|exp_vec));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req_z  = 4'b1111;
        req_r  = 4'b1111;
        w_z    = 16'h1111;
        w_r    = 16'h1111;

        // Reset state: outputs forced low even with requests pending
        #2;
        chk_z("rst_z", 4'b0000);
        chk_r("rst_r", 4'b0000);
        tick();
        chk_z("rst_z_edge", 4'b0000);
        chk_r("rst_r_edge", 4'b0000);
        req_z = 4'b0000;
        req_r = 4'b0000;
        tick();
        rst = 1'b0;

        // Lone requester, same-cycle grant, held, then same-cycle release
        req_z = 4'b0001;
        #1 chk_z("s1_first", 4'b0001);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_z("s1_hold", 4'b0001);
        end
        tick();
        req_z = 4'b0000;
        #1 chk_z("s1_drop", 4'b0000);

        // Weighted rotation with all ports requesting
        do_reset();
        w_z   = 16'h4321;
        req_z = 4'b1111;
        for (int k = 0; k < 13; k++) begin
            #1 chk_z("s2_seq", 4'(1 << seq2[k]));
            tick();
        end

        // Zero weights act as one; release mid-grant moves grant same cycle
        do_reset();
        w_z   = 16'h0000;
        req_z = 4'b1010;
        #1 chk_z("s3_a", 4'b0010);
        tick();
        chk_z("s3_b", 4'b1000);
        tick();
        chk_z("s3_c", 4'b0010);
        tick();
        chk_z("s3_d", 4'b1000);
        tick();
        req_z = 4'b0010;
        #1 chk_z("s3_release", 4'b0010);

        // Lone requester holds forever; counter saturates; pre-emption on new request
        do_reset();
        w_z   = 16'h0200;
        req_z = 4'b0100;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (k % 8 == 0) chk_z("s4_hold", 4'b0100);
            tick();
        end
        chk("s4_sat", 32'(dut_z.hold_cnt_q), 32'hF);
        chk_z("s4_still", 4'b0100);
        req_z = 4'b0101;
        #1 chk_z("s4_preempt", 4'b0001);
        tick();

        // Weight raised during ownership extends the quantum; lowering it pre-empts
        do_reset();
        w_z   = 16'h0001;
        req_z = 4'b0011;
        #1 chk_z("s4w_a", 4'b0001);
        w_z = 16'h0003;
        tick();
        chk_z("s4w_keep", 4'b0001);
        tick();
        chk_z("s4w_keep2", 4'b0001);
        w_z = 16'h0002;
        #1 chk_z("s4w_preempt", 4'b0010);

        // Registered mode: one-cycle latency on grant and on release
        do_reset();
        w_r   = 16'h4444;
        req_r = 4'b0000;
        #1 chk_r("s5_idle", 4'b0000);
        tick();
        req_r = 4'b0011;
        #1 chk_r("s5_req_cycle", 4'b0000);
        tick();
        chk_r("s5_grant", 4'b0001);
        req_r = 4'b0010;
        #1 chk_r("s5_drop_cycle", 4'b0001);
        tick();
        chk_r("s5_move", 4'b0010);

        // Async reset mid-grant, then restart scanning at port 0
        do_reset();
        w_z   = 16'h1111;
        req_z = 4'b1111;
        req_r = 4'b1111;
        #1 chk_z("s6_a", 4'b0001);
        tick();
        chk_z("s6_b", 4'b0010);
        chk_r("s6_r", 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk_z("s6_async_z", 4'b0000);
        chk_r("s6_async_r", 4'b0000);
        tick();
        rst = 1'b0;
        #1 chk_z("s6_restart_z", 4'b0001);
        chk_r("s6_restart_r0", 4'b0000);
        tick();
        chk_r("s6_restart_r", 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
